// File: rtl/outpkt_tx16.sv
// Packet transmitter: header, header checksum, payload and payload checksum
// emitted as 16-bit words into an output FIFO with full/empty flow control.
module outpkt_tx16 #(
  parameter logic [7:0] VERSION          = 8'd2,
  parameter bit         DISABLE_CHECKSUM = 1'b0
) (
  input  logic        PKT_COMM_CLK,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  pkt_type,
  input  logic [15:0] pkt_id,
  input  logic [7:0]  len_dw,
  input  logic [15:0] din,
  input  logic        din_empty,
  output logic        din_rd_en,
  output logic [15:0] dout,
  output logic        wr_en,
  input  logic        full,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_HCS,
    S_DATA,
    S_DCS
  } state_t;

  state_t      r_state;
  logic [8:0]  r_cnt;
  logic [7:0]  r_type;
  logic [15:0] r_id;
  logic [7:0]  r_len;
  logic [15:0] r_lo;
  logic [31:0] r_hacc;
  logic [31:0] r_dacc;
  logic [15:0] r_dout;
  logic        r_wr_en;
  logic        r_wr_last;

  state_t      w_nxt;
  logic [8:0]  w_cnt_nxt;
  logic        w_sel;
  logic [15:0] w_word;
  logic        w_accept;
  logic        w_last;
  logic [8:0]  w_dterm;
  logic [31:0] w_hcs;
  logic [31:0] w_dcs;

  assign w_dterm = {r_len, 1'b0} - 9'd1;
  assign w_hcs   = DISABLE_CHECKSUM ? 32'h0000_0000 : ~r_hacc;
  assign w_dcs   = DISABLE_CHECKSUM ? 32'h0000_0000 : ~r_dacc;

  always_ff @(posedge PKT_COMM_CLK or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_sel     = 1'b0;
    w_word    = 16'h0000;
    w_accept  = 1'b0;
    w_last    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // the cycle carrying the previous packet's last word still counts as busy
        if (start && (len_dw != 8'd0) && !r_wr_last) begin
          w_accept  = 1'b1;
          w_nxt     = S_HDR;
          w_cnt_nxt = 9'd0;
        end
      end
      S_HDR: begin
        case (r_cnt[1:0])
          2'd0:    w_word = {r_type, VERSION};
          2'd1:    w_word = r_id;
          2'd2:    w_word = {6'b000000, r_len, 2'b00};
          default: w_word = 16'h0000;
        endcase
        if (!full) begin
          w_sel = 1'b1;
          if (r_cnt[1:0] == 2'd3) begin
            w_nxt     = S_HCS;
            w_cnt_nxt = 9'd0;
          end else begin
            w_cnt_nxt = r_cnt + 9'd1;
          end
        end
      end
      S_HCS: begin
        w_word = r_cnt[0] ? w_hcs[31:16] : w_hcs[15:0];
        if (!full) begin
          w_sel = 1'b1;
          if (r_cnt[0]) begin
            w_nxt     = S_DATA;
            w_cnt_nxt = 9'd0;
          end else begin
            w_cnt_nxt = r_cnt + 9'd1;
          end
        end
      end
      S_DATA: begin
        w_word = din;
        if (!full && !din_empty) begin
          w_sel = 1'b1;
          if (r_cnt == w_dterm) begin
            w_nxt     = S_DCS;
            w_cnt_nxt = 9'd0;
          end else begin
            w_cnt_nxt = r_cnt + 9'd1;
          end
        end
      end
      S_DCS: begin
        w_word = r_cnt[0] ? w_dcs[31:16] : w_dcs[15:0];
        if (!full) begin
          w_sel = 1'b1;
          if (r_cnt[0]) begin
            w_nxt     = S_IDLE;
            w_cnt_nxt = 9'd0;
            w_last    = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 9'd1;
          end
        end
      end
      default: begin
        w_nxt     = S_IDLE;
        w_cnt_nxt = 9'd0;
      end
    endcase
  end

  always_ff @(posedge PKT_COMM_CLK or posedge rst) begin
    if (rst) begin
      r_cnt     <= 9'd0;
      r_type    <= 8'h00;
      r_id      <= 16'h0000;
      r_len     <= 8'h00;
      r_lo      <= 16'h0000;
      r_hacc    <= 32'h0000_0000;
      r_dacc    <= 32'h0000_0000;
      r_dout    <= 16'h0000;
      r_wr_en   <= 1'b0;
      r_wr_last <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_wr_en   <= w_sel;
      r_wr_last <= w_sel & w_last;
      if (w_sel) r_dout <= w_word;
      if (w_accept) begin
        r_type <= pkt_type;
        r_id   <= pkt_id;
        r_len  <= len_dw;
        r_hacc <= 32'h0000_0000;
        r_dacc <= 32'h0000_0000;
      end
      // even word is parked, odd word completes a 32-bit term
      if (w_sel && !r_cnt[0]) r_lo <= w_word;
      if (w_sel && r_cnt[0]) begin
        if (r_state == S_HDR)  r_hacc <= r_hacc + {w_word, r_lo};
        if (r_state == S_DATA) r_dacc <= r_dacc + {w_word, r_lo};
      end
    end
  end

  assign din_rd_en = (r_state == S_DATA) & !din_empty & !full;
  assign dout      = r_dout;
  assign wr_en     = r_wr_en;
  assign busy      = (r_state != S_IDLE) | r_wr_last;

endmodule

// File: tb/tb_outpkt_tx16.sv
// Scoreboard bench for outpkt_tx16: checksummed and checksum-disabled
// instances share stimulus; a monitor pops expected words on every write.
module tb_outpkt_tx16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  pkt_type;
  logic [15:0] pkt_id;
  logic [7:0]  len_dw;
  logic [15:0] din;
  logic        din_empty;
  logic        full;
  logic        rd0, wr0, busy0;
  logic        rd1, wr1, busy1;
  logic [15:0] dout0, dout1;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt0 = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  bit          ql[$];
  logic [15:0] src[$];
  logic [15:0] dq[$];
  bit          gate = 1'b0;
  bit          full_prev = 1'b0;
  bit          chk_busy_low = 1'b0;

  outpkt_tx16 #(.VERSION(8'd2), .DISABLE_CHECKSUM(1'b0)) u_dut0 (
    .PKT_COMM_CLK(clk), .rst(rst), .start(start), .pkt_type(pkt_type),
    .pkt_id(pkt_id), .len_dw(len_dw), .din(din), .din_empty(din_empty),
    .din_rd_en(rd0), .dout(dout0), .wr_en(wr0), .full(full), .busy(busy0)
  );

  outpkt_tx16 #(.VERSION(8'd2), .DISABLE_CHECKSUM(1'b1)) u_dut1 (
    .PKT_COMM_CLK(clk), .rst(rst), .start(start), .pkt_type(pkt_type),
    .pkt_id(pkt_id), .len_dw(len_dw), .din(din), .din_empty(din_empty),
    .din_rd_en(rd1), .dout(dout1), .wr_en(wr1), .full(full), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pushw(input logic [15:0] w, input bit is_cs, input bit last);
    q0.push_back(w);
    q1.push_back(is_cs ? 16'h0000 : w);
    ql.push_back(last);
  endtask

  task automatic load_src();
    foreach (dq[i]) src.push_back(dq[i]);
  endtask

  // expected packet computed directly from the definition of the format
  task automatic model_pkt(input logic [7:0] t, input logic [15:0] id, input logic [7:0] l);
    logic [31:0] hs, ds;
    hs = {id, t, 8'h02} + {16'h0000, 6'h00, l, 2'b00};
    hs = ~hs;
    ds = 32'h0;
    for (int k = 0; k < l; k++) ds = ds + {dq[2*k+1], dq[2*k]};
    ds = ~ds;
    pushw({t, 8'h02}, 0, 0);
    pushw(id, 0, 0);
    pushw({6'h00, l, 2'b00}, 0, 0);
    pushw(16'h0000, 0, 0);
    pushw(hs[15:0], 1, 0);
    pushw(hs[31:16], 1, 0);
    foreach (dq[i]) pushw(dq[i], 0, 0);
    pushw(ds[15:0], 1, 0);
    pushw(ds[31:16], 1, 1);
  endtask

  task automatic push_ref_pkt();
    pushw(16'h0202, 0, 0); pushw(16'h1234, 0, 0);
    pushw(16'h0004, 0, 0); pushw(16'h0000, 0, 0);
    pushw(16'hFDF9, 1, 0); pushw(16'hEDCB, 1, 0);
    pushw(16'h5678, 0, 0); pushw(16'h9ABC, 0, 0);
    pushw(16'hA987, 1, 0); pushw(16'h6543, 1, 1);
  endtask

  task automatic send(input logic [7:0] t, input logic [15:0] id, input logic [7:0] l);
    @(posedge clk); #1;
    pkt_type = t; pkt_id = id; len_dw = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; pkt_type = ~t; pkt_id = ~id; len_dw = l + 8'd3;
    chk("busy_on_accept", {31'h0, busy0}, 32'h1);
    chk("no_early_write", {31'h0, wr0}, 32'h0);
    @(posedge clk); #1;
    chk("first_write_latency", {15'h0, wr0, dout0}, {15'h0, 1'b1, t, 8'h02});
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && !busy0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("packet_done_in_budget", {31'h0, ok}, 32'h1);
  endtask

  task automatic wait_writes(input int target, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (wr_cnt0 >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("write_count_reached", {31'h0, ok}, 32'h1);
  endtask

  // first-word-fall-through source FIFO model
  initial begin
    bit pend;
    din = 16'h0000;
    din_empty = 1'b1;
    forever begin
      @(negedge clk);
      pend = rd0;
      @(posedge clk); #1;
      if (pend && src.size() > 0) void'(src.pop_front());
      din_empty = (src.size() == 0) || (gate && ($urandom_range(0, 1) == 1));
      din = (src.size() > 0) ? src[0] : 16'h0000;
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [15:0] e;
    bit l;
    if (rst) begin
      chk_busy_low = 1'b0;
    end else begin
      if (chk_busy_low) chk("busy_fall", {31'h0, busy0}, 32'h0);
      chk_busy_low = 1'b0;
      if (wr0) begin
        wr_cnt0++;
        chk("no_write_beyond_slack", {31'h0, full_prev}, 32'h0);
        if (q0.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_write0: got %h expected no write", dout0);
        end else begin
          e = q0.pop_front();
          l = ql.pop_front();
          chk("word_dut0", {16'h0, dout0}, {16'h0, e});
          if (l) begin
            chk("busy_last_word0", {31'h0, busy0}, 32'h1);
            chk("busy_last_word1", {31'h0, busy1}, 32'h1);
            chk_busy_low = 1'b1;
          end
        end
      end
      if (wr1) begin
        if (q1.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_write1: got %h expected no write", dout1);
        end else begin
          e = q1.pop_front();
          chk("word_dut1_nocs", {16'h0, dout1}, {16'h0, e});
        end
      end
    end
    full_prev = full;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst = 1'b1; start = 1'b0; pkt_type = 8'h00; pkt_id = 16'h0000;
    len_dw = 8'h00; full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wr_en", {31'h0, wr0}, 32'h0);
    chk("reset_busy", {31'h0, busy0}, 32'h0);
    chk("reset_rd_en", {31'h0, rd0}, 32'h0);
    chk("reset_dout", {16'h0, dout0}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // reference packet, both checksum modes
    dq = {16'h5678, 16'h9ABC};
    load_src();
    push_ref_pkt();
    send(8'h02, 16'h1234, 8'd1);
    wait_idle(100);

    // same packet with a 5-cycle full stall after the third write
    load_src();
    push_ref_pkt();
    base = wr_cnt0;
    send(8'h02, 16'h1234, 8'd1);
    wait_writes(base + 3, 50);
    @(posedge clk); #1;
    full = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    full = 1'b0;
    wait_idle(100);

    // carries across the 32-bit boundary
    dq = {16'h0001, 16'h8000, 16'hFFFF, 16'hFFFF};
    load_src();
    model_pkt(8'hA5, 16'hFFFF, 8'd2);
    send(8'hA5, 16'hFFFF, 8'd2);
    wait_idle(100);

    // maximum length with a randomly starving source
    dq.delete();
    for (int i = 0; i < 510; i++) dq.push_back(i[15:0]);
    load_src();
    model_pkt(8'h3C, 16'hBEEF, 8'd255);
    gate = 1'b1;
    send(8'h3C, 16'hBEEF, 8'd255);
    wait_idle(4000);
    gate = 1'b0;

    // reset after third payload word
    dq = {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    load_src();
    model_pkt(8'h44, 16'h5555, 8'd3);
    base = wr_cnt0;
    send(8'h44, 16'h5555, 8'd3);
    wait_writes(base + 9, 100);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_wr_en", {31'h0, wr0}, 32'h0);
    chk("midrst_busy", {31'h0, busy0}, 32'h0);
    chk("midrst_rd_en", {30'h0, rd0, rd1}, 32'h0);
    chk("midrst_dout", {16'h0, dout0}, 32'h0);
    @(posedge clk); #1;
    src.delete(); q0.delete(); q1.delete(); ql.delete();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    dq = {16'hCAFE, 16'h0BAD, 16'hF00D, 16'h1234};
    load_src();
    model_pkt(8'h7E, 16'h0BEE, 8'd2);
    send(8'h7E, 16'h0BEE, 8'd2);
    wait_idle(100);

    // zero-length start is ignored
    @(posedge clk); #1;
    start = 1'b1; len_dw = 8'd0; pkt_type = 8'h99;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("len0_not_busy", {31'h0, busy0}, 32'h0);
    repeat (10) @(negedge clk);

    // start while busy is ignored
    dq = {16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
    load_src();
    model_pkt(8'h11, 16'h2222, 8'd2);
    send(8'h11, 16'h2222, 8'd2);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; pkt_type = 8'hFF; len_dw = 8'd5;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(100);
    repeat (20) @(negedge clk);
    chk("no_extra_packet_busy", {31'h0, busy0}, 32'h0);
    chk("queue0_drained", q0.size(), 32'h0);
    chk("queue1_drained", q1.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
